ifu_fetch: RTL and testbench

Instruction fetch unit that produces the instruction stream consumed by the id decoder. It holds the PC, issues word requests to instruction memory over a valid/ready request channel and receives in-order responses. Responses are buffered in a small prefetch FIFO. The FIFO head is presented to decode as a full instruction plus the opcode/func3/func7 fields. A redirect from the jal/jalr/branch resolution path flushes the buffer and discards stale in-flight responses.

---
 rtl/ifu_fetch_pkg.sv | 41 ++++
 rtl/ifu_fifo.sv | 77 +++++++
 rtl/ifu_fetch.sv | 174 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its consumers.
// The opcode constants match the ones used by the decoder, so field
// extraction stays consistent on both sides of the fetch/decode boundary.
package ifu_fetch_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int INST_W     = 32;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    // BOOT: one idle cycle after reset; RUN: normal fetch;
    // FLUSH: stale responses from before a redirect are still arriving.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic [6:0] inst_opcode(input logic [INST_W-1:0] i);
        return i[6:0];
    endfunction

    function automatic logic [2:0] inst_func3(input logic [INST_W-1:0] i);
        return i[14:12];
    endfunction

    function automatic logic [6:0] inst_func7(input logic [INST_W-1:0] i);
        return i[31:25];
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO: DEPTH entries of W bits, occupancy count, synchronous flush
// that overrides push/pop, and simultaneous push/pop (legal even when full).
// The head is read straight from the array so a pushed entry is visible the
// cycle after the push, never in the same cycle.
module ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW:0]   count_reg;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (PW+1)'(DEPTH));
    assign do_push   = push && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

    // Entry storage: data words carry no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The issue rule upstream reserves space for every live request,
    // so a push into a full FIFO without a matching pop is a design bug.
    always @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word requests to instruction
// memory, matches in-order responses to their PCs, buffers them in the
// prefetch FIFO and presents the head to decode. A redirect empties the
// FIFO, retargets the PC and marks every outstanding response as stale.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int            AW       = AW_DEFAULT,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [AW-1:0]     imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect,
    input  logic [AW-1:0]     redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [AW-1:0]     inst_pc,
    output logic [6:0]        opcode,
    output logic [2:0]        func3,
    output logic [6:0]        func7
);

    localparam int PW = $clog2(DEPTH);
    // Stale requests plus a full window of live ones can exceed DEPTH, so the
    // counters get headroom; issue also stops before the counter would wrap.
    localparam int CW = PW + 3;
    localparam int FW = INST_W + AW;

    fetch_state_e   state_reg;
    fetch_state_e   state_next;
    logic [AW-1:0]  pc_reg;
    logic [CW-1:0]  inflight_reg;
    logic [CW-1:0]  inflight_next;
    logic [CW-1:0]  stale_reg;
    logic [CW-1:0]  stale_next;
    logic [AW-1:0]  pcq_reg [DEPTH];
    logic [PW-1:0]  pcq_rd_ptr_reg;
    logic [PW-1:0]  pcq_wr_ptr_reg;

    logic [PW:0]    fifo_count;
    logic [FW-1:0]  fifo_head;
    logic           fifo_empty;
    logic [CW-1:0]  occupancy;
    logic           fetch_allowed;
    logic           req_accept;
    logic           rsp_live;
    logic           inst_fire;
    logic           unused_bits;

    // Only word-aligned targets are fetched; the low redirect bits are dropped.
    assign unused_bits = &redirect_pc[1:0];

    // Live requests plus buffered entries must never exceed the FIFO size.
    assign occupancy     = (inflight_reg - stale_reg) + CW'(fifo_count);
    assign fetch_allowed = (occupancy < CW'(DEPTH)) && (inflight_reg != '1);
    assign req_accept    = imem_req_valid && imem_req_ready;
    assign rsp_live      = imem_rsp_valid && (stale_reg == '0) && !redirect;
    assign inst_fire     = inst_valid && inst_ready;
    assign inflight_next = inflight_reg + CW'(req_accept) - CW'(imem_rsp_valid);

    // Stale tracking: a redirect turns every outstanding request stale, minus
    // the one whose response is being dropped this very cycle.
    always_comb begin
        stale_next = stale_reg;
        if (redirect) begin
            stale_next = inflight_reg - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (stale_reg != '0)) begin
            stale_next = stale_reg - CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: FLUSH lasts while stale responses are still due.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BOOT:  state_next = ST_RUN;
            ST_RUN:   if (redirect && (stale_next != '0)) state_next = ST_FLUSH;
            ST_FLUSH: if (stale_next == '0) state_next = ST_RUN;
            default:  state_next = ST_BOOT;
        endcase
    end

    // FSM outputs: request whenever there is room, except on a redirect cycle.
    always_comb begin
        imem_req_valid = 1'b0;
        if ((state_reg != ST_BOOT) && !redirect && fetch_allowed) begin
            imem_req_valid = 1'b1;
        end
    end

    // PC and outstanding-request counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg       <= PC_RESET;
            inflight_reg <= '0;
            stale_reg    <= '0;
        end else begin
            inflight_reg <= inflight_next;
            stale_reg    <= stale_next;
            if (redirect) begin
                pc_reg <= {redirect_pc[AW-1:2], 2'b00};
            end else if (req_accept) begin
                pc_reg <= pc_reg + AW'(4);
            end
        end
    end

    // PC queue storage: the PC of each accepted request, in issue order.
    always_ff @(posedge clk) begin
        if (req_accept) begin
            pcq_reg[pcq_wr_ptr_reg] <= pc_reg;
        end
    end

    // PC queue pointers. Only live requests are kept: a redirect (which never
    // coincides with an acceptance) discards every queued PC at once, so the
    // stale responses that follow never touch the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcq_rd_ptr_reg <= '0;
            pcq_wr_ptr_reg <= '0;
        end else begin
            if (req_accept) begin
                pcq_wr_ptr_reg <= pcq_wr_ptr_reg + PW'(1);
            end
            if (redirect) begin
                pcq_rd_ptr_reg <= pcq_wr_ptr_reg;
            end else if (rsp_live) begin
                pcq_rd_ptr_reg <= pcq_rd_ptr_reg + PW'(1);
            end
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (rsp_live),
        .push_data ({imem_rsp_data, pcq_reg[pcq_rd_ptr_reg]}),
        .pop       (inst_fire),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign imem_req_addr = pc_reg;
    assign inst_valid    = !fifo_empty;
    // Head fields read as zero whenever nothing valid is presented.
    assign inst          = inst_valid ? fifo_head[FW-1:AW] : '0;
    assign inst_pc       = inst_valid ? fifo_head[AW-1:0]  : '0;
    assign opcode        = inst_opcode(inst);
    assign func3         = inst_func3(inst);
    assign func7         = inst_func7(inst);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a behavioural in-order instruction memory
// of programmable latency. Memory word at address a is 32'h5AB2_5033 ^ a.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 1;
    int unsigned ecnt = 0;
    int unsigned due_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] req_log[$];

    ifu_fetch #(.AW(32), .DEPTH(4), .PC_RESET(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .func3          (func3),
        .func7          (func7)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h5AB2_5033 ^ a;
    endfunction

    // Memory: acceptance seen mid-cycle, response driven just after the edge
    // that makes it due; latency L means consumed L edges after acceptance.
    initial begin : mem_model
        logic        acc;
        logic [31:0] acc_addr;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc      = imem_req_valid && imem_req_ready && !reset;
            acc_addr = imem_req_addr;
            @(posedge clk);
            ecnt++;
            #1;
            if (reset) begin
                due_q.delete();
                addr_q.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                if (acc) begin
                    due_q.push_back(ecnt + 32'(mem_lat) - 1);
                    addr_q.push_back(acc_addr);
                    req_log.push_back(acc_addr);
                    $display("[%0t] req addr=%h", $time, acc_addr);
                end
                if (due_q.size() > 0 && due_q[0] == ecnt) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(addr_q[0]);
                    void'(due_q.pop_front());
                    void'(addr_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    task automatic after_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset released just after an edge; the next edge is "e1".
    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        req_log.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", imem_req_addr); end
        n_cmp++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL rst_inst: got %h/%h want 0/0", inst, inst_pc); end
        n_cmp++; if (opcode !== 7'h0 || func3 !== 3'h0 || func7 !== 7'h0) begin n_bad++; $display("FAIL rst_fields: got %h/%h/%h want 0", opcode, func3, func7); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL boot_no_req: got %b want 0", imem_req_valid); end
        after_edge();
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL run_req: got %b want 1", imem_req_valid); end
    endtask

    task automatic test_stream();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            after_edge();
            n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL s1_req_valid e%0d: got %b want 1", n, imem_req_valid); end
            n_cmp++; if (imem_req_addr !== 32'((n - 1) * 4)) begin n_bad++; $display("FAIL s1_addr e%0d: got %h want %h", n, imem_req_addr, 32'((n - 1) * 4)); end
            if (n < 3) begin
                n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL s1_early_valid e%0d: got %b want 0", n, inst_valid); end
            end else begin
                n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL s1_inst_valid e%0d: got %b want 1", n, inst_valid); end
                n_cmp++; if (inst_pc !== 32'((n - 3) * 4)) begin n_bad++; $display("FAIL s1_inst_pc e%0d: got %h want %h", n, inst_pc, 32'((n - 3) * 4)); end
                n_cmp++; if (inst !== mem_word(32'((n - 3) * 4))) begin n_bad++; $display("FAIL s1_inst e%0d: got %h want %h", n, inst, mem_word(32'((n - 3) * 4))); end
            end
            if (n == 3) begin
                n_cmp++; if (inst !== 32'h5AB2_5033) begin n_bad++; $display("FAIL s1_first_inst: got %h want 5ab25033", inst); end
                n_cmp++; if (opcode !== 7'h33 || func3 !== 3'h5 || func7 !== 7'h2D) begin n_bad++; $display("FAIL s1_fields: got %h/%h/%h want 33/5/2d", opcode, func3, func7); end
            end
        end
        n_cmp++; if (req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8 || req_log[3] !== 32'hC) begin
            n_bad++; $display("FAIL s1_req_order: got %h %h %h %h want 0 4 8 c", req_log[0], req_log[1], req_log[2], req_log[3]);
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        do_reset();
        repeat (4) after_edge();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin n_bad++; $display("FAIL bp_4th_req: got %b@%h want 1@c", imem_req_valid, imem_req_addr); end
        after_edge();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_stop: got %b want 0", imem_req_valid); end
        for (int i = 0; i < 10; i++) begin
            after_edge();
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_hold_req c%0d: got %b want 0", i, imem_req_valid); end
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL bp_hold_head c%0d: got %b@%h want 1@0", i, inst_valid, inst_pc); end
        end
        n_cmp++; if (req_log.size() != 4) begin n_bad++; $display("FAIL bp_req_count: got %0d want 4", req_log.size()); end
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        after_edge();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL bp_resume: got %b@%h want 1@10", imem_req_valid, imem_req_addr); end
        n_cmp++; if (inst_pc !== 32'h4) begin n_bad++; $display("FAIL bp_next_head: got %h want 4", inst_pc); end
        after_edge();
        n_cmp++; if (req_log[4] !== 32'h10) begin n_bad++; $display("FAIL bp_resume_log: got %h want 10", req_log[4]); end
    endtask

    task automatic test_redirect_flush();
        mem_lat = 3;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        repeat (2) after_edge();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL rd_pre: got %b@%h want 1@4", imem_req_valid, imem_req_addr); end
        @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rd_withdraw: got %b want 0", imem_req_valid); end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL rd_target: got %b@%h want 1@100", imem_req_valid, imem_req_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rd_empty: got %b want 0", inst_valid); end
        for (int k = 5; k <= 8; k++) begin
            after_edge();
            if (k < 8) begin
                n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rd_stale_drop e%0d: got %b@%h want 0", k, inst_valid, inst_pc); end
            end else begin
                n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin n_bad++; $display("FAIL rd_first_pc: got %b@%h want 1@100", inst_valid, inst_pc); end
                n_cmp++; if (inst !== 32'h5AB2_5133) begin n_bad++; $display("FAIL rd_first_data: got %h want 5ab25133", inst); end
            end
        end
    endtask

    task automatic test_unaligned_redirect();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        repeat (4) after_edge();
        @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL ua_no_req: got %b want 0", imem_req_valid); end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL ua_addr: got %b@%h want 1@200", imem_req_valid, imem_req_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL ua_flushed: got %b want 0", inst_valid); end
        after_edge();
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL ua_no_passthru: got %b want 0", inst_valid); end
        after_edge();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'h5AB2_5233) begin
            n_bad++; $display("FAIL ua_head: got %b@%h %h want 1@200 5ab25233", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_redirect_with_rsp();
        mem_lat = 3;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        repeat (4) after_edge();
        @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL rr_pre_head: got %b@%h want 1@0", inst_valid, inst_pc); end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rr_cleared: got %b@%h want 0", inst_valid, inst_pc); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin n_bad++; $display("FAIL rr_target: got %b@%h want 1@300", imem_req_valid, imem_req_addr); end
        for (int k = 7; k <= 10; k++) begin
            after_edge();
            if (k < 10) begin
                n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rr_stale e%0d: got %b@%h want 0", k, inst_valid, inst_pc); end
            end else begin
                n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300 || inst !== 32'h5AB2_5333) begin
                    n_bad++; $display("FAIL rr_head: got %b@%h %h want 1@300 5ab25333", inst_valid, inst_pc, inst);
                end
            end
        end
    endtask

    task automatic test_stall_and_reset();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        do_reset();
        after_edge();
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL st_start: got %b@%h want 1@4", imem_req_valid, imem_req_addr); end
        for (int i = 0; i < 5; i++) begin
            after_edge();
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL st_hold c%0d: got %b@%h want 1@4", i, imem_req_valid, imem_req_addr); end
        end
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h5AB2_5033) begin n_bad++; $display("FAIL st_head: got %b %h want 1 5ab25033", inst_valid, inst); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL st_async_req: got %b@%h want 0@0", imem_req_valid, imem_req_addr); end
        n_cmp++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL st_async_inst: got %b %h@%h want 0 0@0", inst_valid, inst, inst_pc); end
        n_cmp++; if (opcode !== 7'h0 || func3 !== 3'h0 || func7 !== 7'h0) begin n_bad++; $display("FAIL st_async_fields: got %h/%h/%h want 0", opcode, func3, func7); end
        imem_req_ready = 1'b1;
        do_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_unaligned_redirect();
        test_redirect_with_rsp();
        test_stall_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
